// File: rtl/hn_bit_reader.sv
// hn_bit_reader: read sequencer for the Hn bit RAM feeding a valid/ready bit stream via a 2-entry skid FIFO.
// Build option: define HN_RD_REVERSE_EN to issue read addresses in descending order.
module hn_bit_reader #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W-1:0] len_m1,
    output logic              rden,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic              ram_q,
    output logic              bit_data,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              bit_last,
    output logic              busy,
    output logic              done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_len;
    logic [ADDR_W-1:0] r_idx;
    logic              r_inflight;
    logic              r_inflight_last;
    logic              r_done;
    logic [1:0]        r_data;
    logic [1:0]        r_last;
    logic              r_wp;
    logic              r_rp;
    logic [1:0]        r_cnt;

    logic              w_pop;
    logic              w_push;
    logic              w_is_last;
    logic              w_accept;
    logic              w_drained;
    logic [1:0]        w_pending;

    assign w_pop     = bit_valid & bit_ready;
    assign w_push    = r_inflight;
    assign w_is_last = (r_idx == r_len);
    // A pop in the same cycle frees a slot, which keeps 1 bit/clk streaming.
    assign w_pending = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    // r_done is high in the first IDLE cycle, so a start coinciding with done is dropped.
    assign w_accept  = start & ~r_done;
    assign w_drained = (r_cnt == 2'd0) & ~r_inflight;

    always_comb begin
        w_state_nxt = r_state;
        rden        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                rden = (w_pending < 2'd2);
                if (rden && w_is_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_drained) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef HN_RD_REVERSE_EN
    assign rdaddress = rden ? (r_len - r_idx) : '0;
`else
    assign rdaddress = rden ? r_idx : '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len           <= '0;
            r_idx           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done     <= (r_state == S_DRAIN) && w_drained;
            r_inflight <= rden;
            if (rden) r_inflight_last <= w_is_last;
            if ((r_state == S_IDLE) && w_accept) begin
                r_len <= len_m1;
                r_idx <= '0;
            end else if (rden && !w_is_last) begin
                r_idx <= r_idx + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_data <= '0;
            r_last <= '0;
            r_wp   <= 1'b0;
            r_rp   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wp] <= ram_q;
                r_last[r_wp] <= r_inflight_last;
                r_wp         <= ~r_wp;
            end
            if (w_pop) r_rp <= ~r_rp;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign bit_valid = (r_cnt != 2'd0);
    assign bit_data  = bit_valid & r_data[r_rp];
    assign bit_last  = bit_valid & r_last[r_rp];
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;

endmodule

// File: tb/tb_hn_bit_reader.sv
// tb_hn_bit_reader: random-backpressure bench for hn_bit_reader against a queue-based frame model.
module tb_hn_bit_reader;
    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] len_m1 = '0;
    logic              rden;
    logic [ADDR_W-1:0] rdaddress;
    logic              ram_q = 1'b0;
    logic              bit_data;
    logic              bit_valid;
    logic              bit_ready = 1'b0;
    logic              bit_last;
    logic              busy;
    logic              done;

    logic        ram_mem [0:1023];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    hn_bit_reader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .len_m1    (len_m1),
        .rden      (rden),
        .rdaddress (rdaddress),
        .ram_q     (ram_q),
        .bit_data  (bit_data),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_last  (bit_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Registered single-port RAM read: data valid the cycle after rden.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rden) ram_q <= ram_mem[rdaddress];
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // rdy_mode 0: ready always high (timing checked); 1: ready random 50%.
    task automatic run_frame(input int len, input int rdy_mode, input bit pre_started,
                             input bit poke_busy, input bit poke_done, input int rst_at);
        bit exp_bit[$];
        int exp_addr[$];
        int n, iss, xf, lasts, dones, viol, first_v, done_c, e0, budget, rel, a, rdones;
        bit fin, pop;
        n = len + 1;
        iss = 0; xf = 0; lasts = 0; dones = 0; viol = 0; first_v = -1; done_c = -1; fin = 0;
        for (int k = 0; k < n; k++) begin
`ifdef HN_RD_REVERSE_EN
            a = len - k;
`else
            a = k;
`endif
            exp_addr.push_back(a);
            exp_bit.push_back(ram_mem[a]);
        end

        if (!pre_started) begin
            @(negedge clk);
            start  = 1'b1;
            len_m1 = ADDR_W'(len);
        end
        @(negedge clk);
        start = 1'b0;
        e0 = int'(cyc);

        budget = n * 12 + 50;
        for (int c = 0; c < budget && !fin; c++) begin
            if (rst_at >= 0 && xf == rst_at) begin
                rstn = 1'b0;
                #1;
                check_eq("rst_rden", rden, 0);
                check_eq("rst_rdaddress", rdaddress, 0);
                check_eq("rst_valid", bit_valid, 0);
                check_eq("rst_data_last", {bit_data, bit_last}, 0);
                check_eq("rst_busy_done", {busy, done}, 0);
                @(posedge clk);
                @(negedge clk);
                rstn = 1'b1;
                rdones = 0;
                for (int j = 0; j < 6; j++) begin
                    @(negedge clk);
                    #1;
                    if (done || busy || bit_valid) rdones++;
                end
                check_eq("rst_no_done_quiet", rdones, 0);
                return;
            end

            bit_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (poke_busy && c == 6) begin
                start  = 1'b1;
                len_m1 = ADDR_W'(3);
            end else if (poke_busy && c == 7) begin
                start  = 1'b0;
                len_m1 = ADDR_W'(len);
            end
            #1;
            rel = int'(cyc) - e0;
            if (bit_valid && first_v < 0) first_v = rel;
            pop = bit_valid && bit_ready;
            if (rden) begin
                if (iss < n) check_eq("rdaddress", rdaddress, exp_addr[iss]);
                if (iss - xf - int'(pop) >= 2) viol++;
                iss++;
            end
            if (pop) begin
                if (xf < n) begin
                    check_eq("bit_data", bit_data, exp_bit[xf]);
                    check_eq("bit_last", bit_last, (xf == n - 1) ? 1 : 0);
                end
                if (bit_last) lasts++;
                xf++;
            end
            if (done) begin
                dones++;
                done_c = rel;
                fin = 1;
            end
            if (!fin) @(negedge clk);
        end

        check_eq("frame_done", fin, 1);
        check_eq("bits_transferred", xf, n);
        check_eq("reads_issued", iss, n);
        check_eq("last_count", lasts, 1);
        check_eq("done_count", dones, 1);
        check_eq("no_overflow_issue", viol, 0);
        if (rdy_mode == 0) begin
            check_eq("first_valid_cycle", first_v, 2);
            check_eq("done_cycle", done_c, n + 3);
        end

        if (poke_done) begin
            start = 1'b1;
            @(negedge clk);
            #1;
            check_eq("start_in_done_ignored", busy, 0);
            check_eq("done_single_pulse", done, 0);
        end else begin
            @(negedge clk);
            #1;
            check_eq("post_done_busy", busy, 0);
            check_eq("done_single_pulse", done, 0);
        end
    endtask

    initial begin
        int quiet;
        for (int k = 0; k < 1024; k++) ram_mem[k] = k[0] ^ k[3];

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_rden", rden, 0);
        check_eq("reset_rdaddress", rdaddress, 0);
        check_eq("reset_valid", bit_valid, 0);
        check_eq("reset_data_last", {bit_data, bit_last}, 0);
        check_eq("reset_busy_done", {busy, done}, 0);
        rstn = 1'b1;
        quiet = 0;
        repeat (10) begin
            @(negedge clk);
            #1;
            if (rden || bit_valid || busy || done) quiet++;
        end
        check_eq("idle_quiet", quiet, 0);

        run_frame(15,   0, 0, 0, 0, -1);
        run_frame(15,   1, 0, 1, 0, -1);
        run_frame(0,    0, 0, 0, 0, -1);
        run_frame(0,    1, 0, 0, 0, -1);
        run_frame(1023, 0, 0, 0, 0, -1);
        run_frame(7,    1, 0, 0, 1, -1);
        run_frame(7,    0, 1, 0, 0, -1);
        run_frame(15,   1, 0, 0, 0, 5);
        run_frame(7,    0, 0, 0, 0, -1);
        for (int r = 0; r < 4; r++) run_frame(int'($urandom_range(1, 40)), 1, 0, 0, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule
